// File: rtl/t_toggle_rx_if.sv
// Valid/ready event handshake between t_toggle_rx (master) and its consumer (slave).
interface t_toggle_rx_if;
  logic evt_valid;
  logic evt_ready;

  modport master (output evt_valid, input evt_ready);
  modport slave  (input evt_valid, output evt_ready);
endinterface

// File: rtl/t_toggle_rx.sv
// Two-phase toggle receiver: synchronises T_in, counts level transitions as events and hands them out on valid/ready.
// Optional macro T_TOGGLE_RX_ACK_EN adds the Ack_out two-phase acknowledge toggle.
module t_toggle_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             En,
  input  logic             T_in,
  t_toggle_rx_if.master    evt,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
`ifdef T_TOGGLE_RX_ACK_EN
  output logic             Ack_out,
`endif
  output logic             Q_mirror
);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] CNT_NEARFULL = CNT_MAX - CNT_ONE;
  localparam logic             MAX_IS_ONE   = (CNT_MAX == CNT_ONE);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   edge_evt;
  logic                   evt_in;
  logic                   acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], T_in};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign Q_mirror = sync[SYNC_STAGES-1];
  assign edge_evt = Q_mirror ^ prev;
  assign evt_in   = edge_evt & En;
  assign acc      = evt.evt_valid & evt.evt_ready;

  // A simultaneous capture and accept cancels out, so neither branch fires and nothing is dropped even when FULL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= EMPTY;
      pending       <= '0;
      overflow      <= 1'b0;
      evt.evt_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (evt_in && !acc) begin
            pending       <= CNT_ONE;
            evt.evt_valid <= 1'b1;
            state         <= MAX_IS_ONE ? FULL : HOLD;
          end
        end
        HOLD: begin
          if (evt_in && !acc) begin
            pending <= pending + CNT_ONE;
            if (pending == CNT_NEARFULL) state <= FULL;
          end else if (!evt_in && acc) begin
            pending <= pending - CNT_ONE;
            if (pending == CNT_ONE) begin
              state         <= EMPTY;
              evt.evt_valid <= 1'b0;
            end
          end
        end
        FULL: begin
          if (evt_in && !acc) begin
            overflow <= 1'b1;
          end else if (!evt_in && acc) begin
            pending       <= pending - CNT_ONE;
            state         <= MAX_IS_ONE ? EMPTY : HOLD;
            evt.evt_valid <= !MAX_IS_ONE;
          end
        end
        default: begin
          state         <= EMPTY;
          pending       <= '0;
          evt.evt_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef T_TOGGLE_RX_ACK_EN
  always_ff @(posedge clk) begin
    if (rst)      Ack_out <= 1'b0;
    else if (acc) Ack_out <= ~Ack_out;
  end
`endif

endmodule

// File: tb/tb_t_toggle_rx.sv
// Directed bench for t_toggle_rx: a history-based event model checked every cycle plus literal checkpoints.
// Build with +define+T_TOGGLE_RX_ACK_EN to also check Ack_out.
module tb_t_toggle_rx;

  localparam int S    = 2;
  localparam int CW   = 4;
  localparam int MAXP = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          En;
  logic          T_in;
  logic [CW-1:0] pending;
  logic          overflow;
  logic          Q_mirror;
`ifdef T_TOGGLE_RX_ACK_EN
  logic          Ack_out;
`endif

  t_toggle_rx_if bus();

  t_toggle_rx #(.SYNC_STAGES(S), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .En       (En),
    .T_in     (T_in),
    .evt      (bus),
    .pending  (pending),
    .overflow (overflow),
`ifdef T_TOGGLE_RX_ACK_EN
    .Ack_out  (Ack_out),
`endif
    .Q_mirror (Q_mirror)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: the line level sampled at each edge; an event is a level change seen S edges late, gated by En.
  bit lvl[$];
  int mCnt   = 0;
  bit mOvf   = 0;
  bit mAck   = 0;
  bit mQ     = 0;
  bit mArmed = 0;

  always @(posedge clk) begin
    bit mEvt;
    bit mAcc;
    if (rst) begin
      lvl.delete();
      for (int i = 0; i < S + 2; i++) lvl.push_back(1'b0);
      mCnt   = 0;
      mOvf   = 0;
      mAck   = 0;
      mQ     = 0;
      mArmed = 1;
    end else if (mArmed) begin
      lvl.push_front(T_in);
      void'(lvl.pop_back());
      mEvt = (lvl[S] != lvl[S+1]) && En;
      mAcc = (mCnt != 0) && bus.evt_ready;
      if (mEvt && !mAcc) begin
        if (mCnt < MAXP) mCnt++;
        else             mOvf = 1;
      end else if (!mEvt && mAcc) begin
        mCnt--;
      end
      if (mAcc) mAck = !mAck;
      mQ = lvl[S-1];
    end
  end

  bit countEn  = 0;
  int accepts  = 0;
  int maxPend  = 0;

  always @(negedge clk) begin
    if (mArmed) begin
      checkOutput("model_pending",   int'(pending),       mCnt);
      checkOutput("model_evt_valid", int'(bus.evt_valid), int'(mCnt != 0));
      checkOutput("model_overflow",  int'(overflow),      int'(mOvf));
      checkOutput("model_q_mirror",  int'(Q_mirror),      int'(mQ));
`ifdef T_TOGGLE_RX_ACK_EN
      checkOutput("model_ack_out",   int'(Ack_out),       int'(mAck));
`endif
    end
    if (countEn) begin
      if (bus.evt_valid && bus.evt_ready) accepts++;
      if (int'(pending) > maxPend) maxPend = int'(pending);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int toggles, input int spacing);
    for (int i = 0; i < toggles; i++) begin
      T_in = ~T_in;
      tick(spacing);
    end
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b1;
    tick(cycles);
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    En            = 1'b1;
    T_in          = 1'b0;
    bus.evt_ready = 1'b0;
    tick(2);
    checkOutput("reset_pending",  int'(pending),       0);
    checkOutput("reset_valid",    int'(bus.evt_valid), 0);
    checkOutput("reset_overflow", int'(overflow),      0);
    checkOutput("reset_q_mirror", int'(Q_mirror),      0);
    rst = 1'b0;

    // Single event: mirror at edge 1, counted at edge 2, then one accept.
    T_in = 1'b1;
    tick(2);
    checkOutput("single_q_mirror_e1", int'(Q_mirror),      1);
    checkOutput("single_valid_e1",    int'(bus.evt_valid), 0);
    tick(1);
    checkOutput("single_pending_e2",  int'(pending),       1);
    checkOutput("single_valid_e2",    int'(bus.evt_valid), 1);
    bus.evt_ready = 1'b1;
    tick(1);
    bus.evt_ready = 1'b0;
    checkOutput("single_pending_acc", int'(pending),       0);
    checkOutput("single_valid_acc",   int'(bus.evt_valid), 0);
`ifdef T_TOGGLE_RX_ACK_EN
    checkOutput("single_ack",         int'(Ack_out),       1);
`endif

    // Saturation: 17 toggles, then drain 15.
    applyStimulus(17, 4);
    checkOutput("sat_pending",  int'(pending),  15);
    checkOutput("sat_overflow", int'(overflow), 1);
    bus.evt_ready = 1'b1;
    tick(15);
    bus.evt_ready = 1'b0;
    checkOutput("drain_pending",  int'(pending),       0);
    checkOutput("drain_valid",    int'(bus.evt_valid), 0);
    checkOutput("drain_overflow", int'(overflow),      1);

    // Full counter with a capture and an accept on the same edge.
    T_in = 1'b0;
    doReset(2);
    tick(4);
    applyStimulus(15, 4);
    checkOutput("full_pending", int'(pending), 15);
    T_in = ~T_in;
    tick(2);
    bus.evt_ready = 1'b1;
    tick(1);
    bus.evt_ready = 1'b0;
    checkOutput("full_simul_pending",  int'(pending),  15);
    checkOutput("full_simul_overflow", int'(overflow), 0);

    // Transitions while disabled are lost for good.
    T_in = 1'b0;
    doReset(2);
    tick(4);
    En = 1'b0;
    applyStimulus(3, 4);
    checkOutput("en_off_pending", int'(pending), 0);
    En = 1'b1;
    applyStimulus(1, 4);
    checkOutput("en_on_pending", int'(pending), 1);

    // Reset with pending=5 and the line held high.
    applyStimulus(5, 4);
    bus.evt_ready = 1'b1;
    tick(1);
    bus.evt_ready = 1'b0;
    checkOutput("pre_rst_pending", int'(pending), 5);
    checkOutput("pre_rst_t_in",    int'(T_in),    1);
    rst = 1'b1;
    tick(1);
    checkOutput("mid_rst_pending",  int'(pending),  0);
    checkOutput("mid_rst_overflow", int'(overflow), 0);
`ifdef T_TOGGLE_RX_ACK_EN
    checkOutput("mid_rst_ack",      int'(Ack_out),  0);
`endif
    tick(1);
    rst = 1'b0;
    tick(2);
    checkOutput("post_rst_pending_e1", int'(pending), 0);
    tick(1);
    checkOutput("post_rst_pending_e2", int'(pending), 1);

    // Continuous ready, 10 events every 3 cycles.
    T_in = 1'b0;
    doReset(2);
    tick(4);
    countEn       = 1'b1;
    bus.evt_ready = 1'b1;
    applyStimulus(10, 3);
    tick(4);
    countEn       = 1'b0;
    bus.evt_ready = 1'b0;
    checkOutput("stream_accepts", accepts, 10);
    checkOutput("stream_max_pend", maxPend, 1);
    checkOutput("stream_pending", int'(pending), 0);
`ifdef T_TOGGLE_RX_ACK_EN
    checkOutput("stream_ack", int'(Ack_out), 0);
`endif

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/t_toggle_rx.md
Name: t_toggle_rx

Overview:
- Receiving end of a toggle-signalled (two-phase) link driven by a remote T latch/flip-flop.
- Each level transition on T_in is one event. The block synchronises T_in into the local clock domain, detects transitions and counts pending events in a saturating counter.
- Events are delivered one at a time on a valid/ready handshake; an optional two-phase acknowledge toggle is returned to the sender.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on T_in; minimum 2.
- CNT_W, 4, width of the pending-event counter; maximum pending = 2**CNT_W-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- En  input  1  event capture enable; 0 = transitions tracked but not counted
- T_in  input  1  toggle line from remote T latch, asynchronous to clk
- evt_valid  output  1  at least one event pending
- evt_ready  input  1  consumer accepts one event when evt_valid=1
- pending  output  CNT_W  current pending-event count
- overflow  output  1  sticky: an event was dropped at saturation
- Q_mirror  output  1  synchronised copy of T_in level (last synchroniser stage)
- Ack_out  output  1  two-phase acknowledge; exists only with T_TOGGLE_RX_ACK_EN

Behaviour:
- Reset (rst=1 at a clk edge) clears all state:
  - synchroniser flops = 0, prev level = 0, pending = 0
  - evt_valid = 0, overflow = 0, Q_mirror = 0, Ack_out = 0
  - Events in flight are discarded.
- Synchroniser: a SYNC_STAGES-deep flop chain. Q_mirror = last stage.
- Transition detect:
  - edge_evt = Q_mirror XOR prev.
  - prev <= Q_mirror every cycle, regardless of En.
  - evt_in = edge_evt AND En.
- Latency:
  - T_in is stable and changed before clk edge 0.
  - Q_mirror updates at edge SYNC_STAGES-1.
  - pending increments at edge SYNC_STAGES; evt_valid=1 after that edge.
  - Default SYNC_STAGES=2: event visible after edge 2.
- Accept: acc = evt_valid AND evt_ready. evt_ready is ignored while evt_valid=0.
- Counter update per cycle:
  - evt_in=1, acc=0, pending<max: pending+1.
  - evt_in=1, acc=0, pending==max: pending unchanged, event dropped, overflow<=1.
  - evt_in=0, acc=1: pending-1.
  - evt_in=1, acc=1: pending unchanged, no drop, including at max.
  - Neither: hold.
- evt_valid = (pending != 0), registered-state derived; no combinational path from evt_ready.
- State machine (encodes counter region, drives evt_valid/overflow logic):
  - EMPTY: pending==0.
  - HOLD: 0<pending<max.
  - FULL: pending==max.
  - EMPTY->HOLD on evt_in without acc.
  - HOLD->EMPTY on acc without evt_in when pending==1.
  - HOLD->FULL on evt_in without acc when pending==max-1.
  - FULL->HOLD on acc without evt_in.
  - FULL stays FULL on evt_in without acc; sets overflow.
- overflow is cleared only by rst.
- En: transitions arriving while En=0 are lost permanently. Re-asserting En does not replay them. The handshake drains normally regardless of En.
- Post-reset: prev=0. If T_in is held at 1 through reset, one event is counted SYNC_STAGES edges after rst deasserts (intended: line level 1 means an odd number of sends).
- Reset mid-operation: takes effect at the same edge. Pending, overflow and Ack_out clear, and the sender's view of Ack_out is reset.

Optional Feature:
- Macro T_TOGGLE_RX_ACK_EN.
- Defined:
  - Ack_out port present.
  - Ack_out registered, reset 0, toggles at every edge where acc=1.
  - The sender compares its T level with Ack_out to know all events have been consumed.
- Undefined:
  - Ack_out port and register absent.
  - All other behaviour identical.

Test Plan:
- Reset, En=1, T_in 0->1 once, evt_ready=0 -> evt_valid=1 after 2nd edge, pending=1, Q_mirror=1; hold evt_ready=1 one cycle -> pending=0, evt_valid=0, Ack_out toggles to 1 (ACK_EN).
- En=1, evt_ready=0, 17 T_in toggles spaced 4 cycles (CNT_W=4) -> pending saturates at 15, overflow=1 after 16th toggle; drain 15 accepts -> pending=0, overflow still 1.
- pending=15, evt_ready=1, and a detected transition in the same cycle -> pending stays 15, overflow stays 0.
- En=0, 3 toggles, then En=1 and 1 toggle -> pending=1 only.
- rst asserted with pending=5 and T_in=1 held -> after reset pending=0, overflow=0, Ack_out=0; rst released -> pending=1 at 2nd edge.
- Continuous evt_ready=1, toggles every 3 cycles for 10 events -> 10 accepts total, pending never exceeds 1, Ack_out ends at 0 (10 toggles).
